// File: rtl/load_store_unit_if.sv
// Request/response and FIFO register bus of the load/store unit.
// slave is the LSU side, master is the CPU plus FIFO device side.
interface load_store_unit_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        fifo_sel_o;
    logic        fifo_rd_o;
    logic        fifo_wr_o;
    logic [1:0]  fifo_addr_o;
    logic [7:0]  fifo_wdata_o;
    logic [7:0]  fifo_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        input  req_size_i, req_unsigned_i, fifo_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output fifo_sel_o, fifo_rd_o, fifo_wr_o, fifo_addr_o, fifo_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        output req_size_i, req_unsigned_i, fifo_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  fifo_sel_o, fifo_rd_o, fifo_wr_o, fifo_addr_o, fifo_wdata_o
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte-lane data RAM plus a 16-byte FIFO register
// window, one outstanding access, single-cycle response pulse.
module load_store_unit #(
    parameter int unsigned RAM_WORDS = 256,
    parameter logic [31:0] FIFO_BASE = 32'h8000_0000
) (
    input logic               clk_i,
    input logic               rstn_i,
    load_store_unit_if.slave  bus
);
    localparam int unsigned AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    typedef enum logic [2:0] {
        IDLE, RAM_RD, FIFO_STB, FIFO_WAIT, RESP
    } state_e;

    state_e      state;
    logic [1:0]  lane_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;

    logic [31:0] mem [RAM_WORDS];
    logic [31:0] rd_word;

    logic          hit_ram;
    logic          hit_fifo;
    logic          misalign;
    logic          fault;
    logic          ram_ok;
    logic          fifo_ok;
    logic          ram_we;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic [AW-1:0] idx;

    assign idx      = bus.req_addr_i[AW+1:2];
    assign hit_ram  = bus.req_addr_i < RAM_BYTES;
    assign hit_fifo = bus.req_addr_i[31:4] == FIFO_BASE[31:4];

    always_comb begin
        misalign  = 1'b0;
        be        = 4'b0000;
        wdata_rep = bus.req_wdata_i;
        unique case (bus.req_size_i)
            2'b00: begin
                be        = 4'b0001 << bus.req_addr_i[1:0];
                wdata_rep = {4{bus.req_wdata_i[7:0]}};
            end
            2'b01: begin
                misalign  = bus.req_addr_i[0];
                be        = 4'b0011 << {bus.req_addr_i[1], 1'b0};
                wdata_rep = {2{bus.req_wdata_i[15:0]}};
            end
            2'b10: begin
                misalign  = |bus.req_addr_i[1:0];
                be        = 4'b1111;
            end
            default: misalign = 1'b1;
        endcase
    end

    // RAM wins the decode if a parameter choice ever overlaps the windows
    assign fault   = misalign | ~(hit_ram | hit_fifo);
    assign ram_ok  = hit_ram & ~fault;
    assign fifo_ok = hit_fifo & ~hit_ram & ~fault;
    assign ram_we  = rstn_i & (state == IDLE) & bus.req_valid_i
                   & ram_ok & bus.req_we_i;

    assign bus.req_ready_o = (state == IDLE);

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
        rd_word <= mem[idx];
    end

    function automatic logic [31:0] extract(
        input logic [31:0] w,
        input logic [1:0]  a,
        input logic [1:0]  sz,
        input logic        u
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {a, 3'b000});
        h = a[1] ? w[31:16] : w[15:0];
        unique case (sz)
            2'b00:   return u ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return u ? {16'b0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state            <= IDLE;
            lane_q           <= 2'b00;
            we_q             <= 1'b0;
            size_q           <= 2'b00;
            uns_q            <= 1'b0;
            bus.rsp_valid_o  <= 1'b0;
            bus.rsp_rdata_o  <= 32'h0;
            bus.rsp_err_o    <= 1'b0;
            bus.fifo_sel_o   <= 1'b0;
            bus.fifo_rd_o    <= 1'b0;
            bus.fifo_wr_o    <= 1'b0;
            bus.fifo_addr_o  <= 2'b00;
            bus.fifo_wdata_o <= 8'h00;
        end else begin
            unique case (state)
                IDLE: if (bus.req_valid_i) begin
                    lane_q <= bus.req_addr_i[1:0];
                    we_q   <= bus.req_we_i;
                    size_q <= bus.req_size_i;
                    uns_q  <= bus.req_unsigned_i;
                    unique case (1'b1)
                        fault: begin
                            state           <= RESP;
                            bus.rsp_valid_o <= 1'b1;
                            bus.rsp_err_o   <= 1'b1;
                            bus.rsp_rdata_o <= 32'h0;
                        end
                        ram_ok & bus.req_we_i: begin
                            state           <= RESP;
                            bus.rsp_valid_o <= 1'b1;
                            bus.rsp_rdata_o <= 32'h0;
                        end
                        ram_ok & ~bus.req_we_i: state <= RAM_RD;
                        fifo_ok: begin
                            state            <= FIFO_STB;
                            bus.fifo_sel_o   <= 1'b1;
                            bus.fifo_rd_o    <= ~bus.req_we_i;
                            bus.fifo_wr_o    <= bus.req_we_i;
                            bus.fifo_addr_o  <= bus.req_addr_i[3:2];
                            bus.fifo_wdata_o <= bus.req_wdata_i[7:0];
                        end
                    endcase
                end
                RAM_RD: begin
                    state           <= RESP;
                    bus.rsp_valid_o <= 1'b1;
                    bus.rsp_rdata_o <= extract(rd_word, lane_q, size_q, uns_q);
                end
                FIFO_STB: begin
                    bus.fifo_sel_o   <= 1'b0;
                    bus.fifo_rd_o    <= 1'b0;
                    bus.fifo_wr_o    <= 1'b0;
                    bus.fifo_addr_o  <= 2'b00;
                    bus.fifo_wdata_o <= 8'h00;
                    if (we_q) begin
                        state           <= RESP;
                        bus.rsp_valid_o <= 1'b1;
                        bus.rsp_rdata_o <= 32'h0;
                    end else begin
                        state <= FIFO_WAIT;
                    end
                end
                FIFO_WAIT: begin
                    state           <= RESP;
                    bus.rsp_valid_o <= 1'b1;
                    bus.rsp_rdata_o <= {24'b0, bus.fifo_rdata_i};
                end
                RESP: begin
                    state           <= IDLE;
                    bus.rsp_valid_o <= 1'b0;
                    bus.rsp_rdata_o <= 32'h0;
                    bus.rsp_err_o   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: RAM lanes, FIFO window, faults,
// reset mid-access and back-to-back requests.
module tb_load_store_unit;
    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;
    int   checks = 0;
    int   errors = 0;

    load_store_unit_if bus ();

    load_store_unit #(
        .RAM_WORDS(256),
        .FIFO_BASE(32'h8000_0000)
    ) dut (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // FIFO device: read data appears the cycle after the read strobe
    logic [7:0] fifo_rd_val = 8'h00;
    always @(posedge clk_i)
        bus.fifo_rdata_i <= (bus.fifo_sel_o && bus.fifo_rd_o) ? fifo_rd_val : 8'h00;

    int         stb_cnt = 0;
    logic       last_wr, last_rd;
    logic [1:0] last_fa;
    logic [7:0] last_fw;
    always @(negedge clk_i) begin
        if (bus.fifo_sel_o) begin
            stb_cnt++;
            last_wr = bus.fifo_wr_o;
            last_rd = bus.fifo_rd_o;
            last_fa = bus.fifo_addr_o;
            last_fw = bus.fifo_wdata_o;
        end
    end

    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size,
                          input logic uns, output logic [31:0] rdata,
                          output logic err, output int lat);
        int wt = 0;
        while (!bus.req_ready_o && wt < 10) begin
            @(posedge clk_i); #1; wt++;
        end
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wdata;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        @(posedge clk_i); #1;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = ~we;
        bus.req_addr_i  = 32'hFFFF_FFFF;
        bus.req_wdata_i = 32'hA5A5_A5A5;
        lat = 1;
        while (!bus.rsp_valid_o && lat < 8) begin
            @(posedge clk_i); #1; lat++;
        end
        if (!bus.rsp_valid_o) lat = 99;
        rdata = bus.rsp_rdata_o;
        err   = bus.rsp_err_o;
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.req_ready_o); end
        checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", bus.rsp_valid_o); end
        checks++; if (bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus.rsp_err_o); end
        checks++; if (bus.rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.rsp_rdata_o); end
        checks++; if ({bus.fifo_sel_o, bus.fifo_rd_o, bus.fifo_wr_o, bus.fifo_addr_o, bus.fifo_wdata_o} !== 13'h0)
            begin errors++; $display("FAIL rst_fifo got %b%b%b %h %h exp all 0", bus.fifo_sel_o, bus.fifo_rd_o, bus.fifo_wr_o, bus.fifo_addr_o, bus.fifo_wdata_o); end
        rstn_i = 1'b1;
        @(posedge clk_i); #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", bus.req_ready_o); end
    endtask

    task automatic test_ram_load;
        logic [31:0] rd; logic er; int lat;
        access(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, rd, er, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL sw_lat got %0d exp 1", lat); end
        checks++; if ({er, rd} !== 33'h0) begin errors++; $display("FAIL sw_rsp got err %b data %h exp 0 0", er, rd); end
        checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rsp_pulse got %b exp 0", bus.rsp_valid_o); end
        access(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, rd, er, lat);
        checks++; if (rd !== 32'hFFFF_FFDE) begin errors++; $display("FAIL lb_signed got %h exp ffffffde", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL load_lat got %0d exp 2", lat); end
        access(1'b0, 32'h10, 32'h0, 2'b01, 1'b1, rd, er, lat);
        checks++; if (rd !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu got %h exp 0000beef", rd); end
        access(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, rd, er, lat);
        checks++; if (rd !== 32'hFFFF_DEAD) begin errors++; $display("FAIL lh_signed got %h exp ffffdead", rd); end
        access(1'b0, 32'h11, 32'h0, 2'b00, 1'b1, rd, er, lat);
        checks++; if (rd !== 32'h0000_00BE) begin errors++; $display("FAIL lbu got %h exp 000000be", rd); end
    endtask

    task automatic test_sub_word_store;
        logic [31:0] rd; logic er; int lat;
        access(1'b1, 32'h20, 32'h0, 2'b10, 1'b0, rd, er, lat);
        access(1'b1, 32'h21, 32'hFFFF_FF5A, 2'b00, 1'b0, rd, er, lat);
        access(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er, lat);
        checks++; if (rd !== 32'h0000_5A00) begin errors++; $display("FAIL sb_lane got %h exp 00005a00", rd); end
        access(1'b1, 32'h22, 32'hABCD_1234, 2'b01, 1'b0, rd, er, lat);
        access(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er, lat);
        checks++; if (rd !== 32'h1234_5A00) begin errors++; $display("FAIL sh_lane got %h exp 12345a00", rd); end
        access(1'b1, 32'h3FC, 32'hCAFE_F00D, 2'b10, 1'b0, rd, er, lat);
        access(1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0, rd, er, lat);
        checks++; if ({er, rd} !== {1'b0, 32'hCAFE_F00D}) begin errors++; $display("FAIL last_word got err %b data %h exp 0 cafef00d", er, rd); end
    endtask

    task automatic test_fifo;
        logic [31:0] rd; logic er; int lat; int s0;
        s0 = stb_cnt;
        access(1'b1, 32'h8000_0004, 32'h1234_5641, 2'b00, 1'b0, rd, er, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL fifo_st_lat got %0d exp 2", lat); end
        checks++; if ({er, rd} !== 33'h0) begin errors++; $display("FAIL fifo_st_rsp got err %b data %h exp 0 0", er, rd); end
        checks++; if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL fifo_st_stb got %0d exp 1", stb_cnt - s0); end
        checks++; if ({last_wr, last_rd, last_fa, last_fw} !== {1'b1, 1'b0, 2'd1, 8'h41})
            begin errors++; $display("FAIL fifo_st_bus got wr %b rd %b a %0d d %h exp 1 0 1 41", last_wr, last_rd, last_fa, last_fw); end
        fifo_rd_val = 8'h9C;
        access(1'b0, 32'h8000_0000, 32'h0, 2'b00, 1'b0, rd, er, lat);
        checks++; if (rd !== 32'h0000_009C) begin errors++; $display("FAIL fifo_ld got %h exp 0000009c", rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL fifo_ld_lat got %0d exp 3", lat); end
        checks++; if ({last_wr, last_rd, last_fa} !== {1'b0, 1'b1, 2'd0}) begin errors++; $display("FAIL fifo_ld_bus got wr %b rd %b a %0d exp 0 1 0", last_wr, last_rd, last_fa); end
        fifo_rd_val = 8'hF0;
        access(1'b0, 32'h8000_000C, 32'h0, 2'b10, 1'b0, rd, er, lat);
        checks++; if ({rd, last_fa} !== {32'h0000_00F0, 2'd3}) begin errors++; $display("FAIL fifo_ld_zext got %h a %0d exp 000000f0 3", rd, last_fa); end
        checks++; if ({bus.fifo_sel_o, bus.fifo_addr_o, bus.fifo_wdata_o} !== 11'h0)
            begin errors++; $display("FAIL fifo_idle got sel %b a %h d %h exp 0", bus.fifo_sel_o, bus.fifo_addr_o, bus.fifo_wdata_o); end
    endtask

    task automatic test_fault;
        logic [31:0] rd; logic er; int lat; int s0;
        access(1'b1, 32'h0, 32'h1122_3344, 2'b10, 1'b0, rd, er, lat);
        access(1'b0, 32'h2, 32'h0, 2'b10, 1'b0, rd, er, lat);
        checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL lw_misalign got err %b data %h exp 1 0", er, rd); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL fault_lat got %0d exp 1", lat); end
        s0 = stb_cnt;
        access(1'b1, 32'h4000_0000, 32'hFFFF_FFFF, 2'b10, 1'b0, rd, er, lat);
        checks++; if ({er, lat} !== {1'b1, 32'd1}) begin errors++; $display("FAIL unmapped_st got err %b lat %0d exp 1 1", er, lat); end
        access(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd, er, lat);
        checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL fault_no_write got %h exp 11223344", rd); end
        access(1'b1, 32'h8000_0005, 32'h77, 2'b01, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL fifo_half_odd got err %b exp 1", er); end
        checks++; if (stb_cnt !== s0) begin errors++; $display("FAIL fault_no_stb got %0d exp %0d", stb_cnt, s0); end
        access(1'b0, 32'h11, 32'h0, 2'b01, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL lh_odd got err %b exp 1", er); end
        access(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL size11 got err %b exp 1", er); end
        access(1'b0, 32'h400, 32'h0, 2'b10, 1'b0, rd, er, lat);
        checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL ram_end got err %b data %h exp 1 0", er, rd); end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = 1'b1;
        bus.req_addr_i     = 32'h8000_0008;
        bus.req_wdata_i    = 32'h77;
        bus.req_size_i     = 2'b00;
        bus.req_unsigned_i = 1'b0;
        @(posedge clk_i); #1;
        bus.req_valid_i = 1'b0;
        checks++; if ({bus.fifo_wr_o, bus.fifo_addr_o} !== {1'b1, 2'd2}) begin errors++; $display("FAIL mid_stb got wr %b a %0d exp 1 2", bus.fifo_wr_o, bus.fifo_addr_o); end
        #1 rstn_i = 1'b0;
        #1;
        checks++; if ({bus.fifo_sel_o, bus.fifo_wr_o} !== 2'b00) begin errors++; $display("FAIL mid_drop got sel %b wr %b exp 0 0", bus.fifo_sel_o, bus.fifo_wr_o); end
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            if (bus.rsp_valid_o) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_rsp got %0d exp 0", seen); end
        checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", bus.req_ready_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_back_to_back;
        int acc = 0;
        int rsp = 0;
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = 1'b0;
        bus.req_addr_i     = 32'h10;
        bus.req_size_i     = 2'b10;
        bus.req_unsigned_i = 1'b0;
        repeat (12) begin
            @(negedge clk_i);
            if (bus.req_valid_i && bus.req_ready_o) acc++;
            if (bus.rsp_valid_o) begin
                rsp++;
                checks++; if (bus.rsp_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_data got %h exp deadbeef", bus.rsp_rdata_o); end
            end
            @(posedge clk_i);
        end
        #1 bus.req_valid_i = 1'b0;
        checks++; if (acc !== 4) begin errors++; $display("FAIL b2b_accepts got %0d exp 4", acc); end
        checks++; if (rsp !== 4) begin errors++; $display("FAIL b2b_rsps got %0d exp 4", rsp); end
        @(posedge clk_i); #1;
    endtask

    initial begin
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_addr_i     = 32'h0;
        bus.req_wdata_i    = 32'h0;
        bus.req_size_i     = 2'b00;
        bus.req_unsigned_i = 1'b0;
        test_reset();
        test_ram_load();
        test_sub_word_store();
        test_fifo();
        test_fault();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
